ap_bitserial_engine: RTL and testbench

- Parametrised associative-processor engine. It holds three word columns A, B and C plus a per-row carry bit across CELL_QUANT rows.
- It executes bit-serial, LUT-driven compare/write passes over all rows in parallel, computing C = A op B.
- It is the next generation of the single-op AP array block. It adds op selection (OR, AND, XOR, ADD) and generic width/depth.
- It adds a start/busy/done handshake and pause on ap_mode. It sits between the host bus and the AP result path.

---
 rtl/ap_bitserial_engine.sv | 268 ++++++++++++++++++++++++++
 tb/tb_ap_bitserial_engine.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_bitserial_engine.sv
`default_nettype none
// ============================================================================
// Module      : ap_bitserial_engine
// Description : Associative-processor engine computing C = A op B (OR, AND,
//               XOR, ADD) with bit-serial LUT compare/write passes over all
//               rows in parallel. Optional macro AP_NZ_COUNT_EN adds a
//               post-operation scan that counts rows with C != 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ap_bitserial_engine #(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 512,
    parameter int ADDR_W     = $clog2(CELL_QUANT)
) (
    input  logic                  CLK100MHZ,
    input  logic                  rst,
    input  logic                  ap_mode,
    input  logic                  start,
    input  logic [2:0]            cmd,
    input  logic [ADDR_W-1:0]     addr_in,
    input  logic [1:0]            sel_col,
    input  logic [WORD_SIZE-1:0]  data_in,
    input  logic                  write_en,
    input  logic                  read_en,
    output logic [WORD_SIZE-1:0]  data_out,
    output logic                  busy,
`ifdef AP_NZ_COUNT_EN
    output logic [$clog2(CELL_QUANT+1)-1:0] nz_count,
`endif
    output logic                  ap_state_irq
);

    localparam int BIT_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

    localparam logic [2:0] C_ST_IDLE    = 3'd0;
    localparam logic [2:0] C_ST_CLEAR   = 3'd1;
    localparam logic [2:0] C_ST_COMPARE = 3'd2;
    localparam logic [2:0] C_ST_WRITE   = 3'd3;
    localparam logic [2:0] C_ST_ADVANCE = 3'd4;
    localparam logic [2:0] C_ST_DONE    = 3'd5;
`ifdef AP_NZ_COUNT_EN
    localparam logic [2:0] C_ST_COUNT   = 3'd6;
    localparam int         NZ_W         = $clog2(CELL_QUANT+1);
`endif

    localparam logic [1:0] C_OP_OR  = 2'd0;
    localparam logic [1:0] C_OP_AND = 2'd1;
    localparam logic [1:0] C_OP_XOR = 2'd2;
    localparam logic [1:0] C_OP_ADD = 2'd3;

    // Pass p of OR/XOR/ADD matches pattern p+1; AND has the single pattern 11.
    function automatic logic [2:0] lut_pattern(input logic [1:0] op, input logic [2:0] pass);
        if (op == C_OP_AND) return 3'b011;
        return pass + 3'd1;
    endfunction

    function automatic logic [2:0] last_pass(input logic [1:0] op);
        case (op)
            C_OP_OR:  return 3'd2;
            C_OP_AND: return 3'd0;
            C_OP_XOR: return 3'd1;
            default:  return 3'd6;
        endcase
    endfunction

    logic [2:0]            state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [2:0]            pass_q, pass_d;
    logic                  busy_q, busy_d;
    logic                  irq_q, irq_d;
    logic [WORD_SIZE-1:0]  dout_q, dout_d;
    logic [CELL_QUANT-1:0] carry_q, carry_d;
    logic [CELL_QUANT-1:0] ncarry_q, ncarry_d;
    logic [CELL_QUANT-1:0] tag_q, tag_d;
    logic [WORD_SIZE-1:0]  col_a_q [CELL_QUANT];
    logic [WORD_SIZE-1:0]  col_a_d [CELL_QUANT];
    logic [WORD_SIZE-1:0]  col_b_q [CELL_QUANT];
    logic [WORD_SIZE-1:0]  col_b_d [CELL_QUANT];
    logic [WORD_SIZE-1:0]  col_c_q [CELL_QUANT];
    logic [WORD_SIZE-1:0]  col_c_d [CELL_QUANT];
`ifdef AP_NZ_COUNT_EN
    logic [ADDR_W-1:0]     row_q, row_d;
    logic [NZ_W-1:0]       cnt_q, cnt_d;
    logic [NZ_W-1:0]       nz_q, nz_d;
`endif

    logic [2:0] w_pat;
    logic       w_sum;
    logic       w_cout;
    logic       w_host;

    assign w_pat  = lut_pattern(op_q, pass_q);
    assign w_sum  = (op_q == C_OP_ADD) ? ^w_pat : 1'b1;
    assign w_cout = (w_pat[2] & w_pat[1]) | (w_pat[2] & w_pat[0]) | (w_pat[1] & w_pat[0]);
    assign w_host = !ap_mode && !busy_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        bit_d    = bit_q;
        pass_d   = pass_q;
        busy_d   = busy_q;
        irq_d    = irq_q;
        dout_d   = dout_q;
        carry_d  = carry_q;
        ncarry_d = ncarry_q;
        tag_d    = tag_q;
        col_a_d  = col_a_q;
        col_b_d  = col_b_q;
        col_c_d  = col_c_q;
`ifdef AP_NZ_COUNT_EN
        row_d    = row_q;
        cnt_d    = cnt_q;
        nz_d     = nz_q;
`endif

        if (w_host && write_en) begin
            case (sel_col)
                2'd0:    col_a_d[addr_in] = data_in;
                2'd1:    col_b_d[addr_in] = data_in;
                2'd2:    col_c_d[addr_in] = data_in;
                default: ;
            endcase
        end
        // Reads sample the pre-write column contents, so same-cycle RAW returns old data.
        if (w_host && read_en) begin
            case (sel_col)
                2'd0:    dout_d = col_a_q[addr_in];
                2'd1:    dout_d = col_b_q[addr_in];
                2'd2:    dout_d = col_c_q[addr_in];
                default: dout_d = '0;
            endcase
        end

        if (ap_mode) begin
            case (state_q)
                C_ST_IDLE: begin
                    if (start && !cmd[2]) begin
                        op_d    = cmd[1:0];
                        busy_d  = 1'b1;
                        irq_d   = 1'b0;
                        state_d = C_ST_CLEAR;
                    end
                end
                C_ST_CLEAR: begin
                    for (int r = 0; r < CELL_QUANT; r++) col_c_d[r] = '0;
                    carry_d  = '0;
                    ncarry_d = '0;
                    bit_d    = '0;
                    pass_d   = '0;
                    state_d  = C_ST_COMPARE;
                end
                C_ST_COMPARE: begin
                    for (int r = 0; r < CELL_QUANT; r++) begin
                        if (op_q == C_OP_ADD)
                            tag_d[r] = ({col_a_q[r][bit_q], col_b_q[r][bit_q], carry_q[r]} == w_pat);
                        else
                            tag_d[r] = ({col_a_q[r][bit_q], col_b_q[r][bit_q]} == w_pat[1:0]);
                    end
                    state_d = C_ST_WRITE;
                end
                C_ST_WRITE: begin
                    for (int r = 0; r < CELL_QUANT; r++) begin
                        if (tag_q[r]) begin
                            col_c_d[r][bit_q] = w_sum;
                            if (op_q == C_OP_ADD) ncarry_d[r] = w_cout;
                        end
                    end
                    if (pass_q == last_pass(op_q)) begin
                        state_d = C_ST_ADVANCE;
                    end else begin
                        pass_d  = pass_q + 3'd1;
                        state_d = C_ST_COMPARE;
                    end
                end
                C_ST_ADVANCE: begin
                    carry_d  = ncarry_q;
                    ncarry_d = '0;
                    pass_d   = '0;
                    if (bit_q == BIT_W'(WORD_SIZE-1)) begin
`ifdef AP_NZ_COUNT_EN
                        row_d   = '0;
                        cnt_d   = '0;
                        state_d = C_ST_COUNT;
`else
                        state_d = C_ST_DONE;
`endif
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        state_d = C_ST_COMPARE;
                    end
                end
`ifdef AP_NZ_COUNT_EN
                C_ST_COUNT: begin
                    if (col_c_q[row_q] != '0) cnt_d = cnt_q + NZ_W'(1);
                    if (row_q == ADDR_W'(CELL_QUANT-1)) begin
                        nz_d    = cnt_d;
                        state_d = C_ST_DONE;
                    end else begin
                        row_d = row_q + ADDR_W'(1);
                    end
                end
`endif
                C_ST_DONE: begin
                    busy_d  = 1'b0;
                    irq_d   = 1'b1;
                    state_d = C_ST_IDLE;
                end
                default: state_d = C_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_q  <= C_ST_IDLE;
            op_q     <= C_OP_OR;
            bit_q    <= '0;
            pass_q   <= '0;
            busy_q   <= 1'b0;
            irq_q    <= 1'b0;
            dout_q   <= '0;
            carry_q  <= '0;
            ncarry_q <= '0;
            tag_q    <= '0;
`ifdef AP_NZ_COUNT_EN
            row_q    <= '0;
            cnt_q    <= '0;
            nz_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            bit_q    <= bit_d;
            pass_q   <= pass_d;
            busy_q   <= busy_d;
            irq_q    <= irq_d;
            dout_q   <= dout_d;
            carry_q  <= carry_d;
            ncarry_q <= ncarry_d;
            tag_q    <= tag_d;
`ifdef AP_NZ_COUNT_EN
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            nz_q     <= nz_d;
`endif
        end
    end

    // Column storage has no reset value; rst only blocks updates on its own cycle.
    always_ff @(posedge CLK100MHZ) begin
        if (!rst) begin
            col_a_q <= col_a_d;
            col_b_q <= col_b_d;
            col_c_q <= col_c_d;
        end
    end

    assign data_out     = dout_q;
    assign busy         = busy_q;
    assign ap_state_irq = irq_q;
`ifdef AP_NZ_COUNT_EN
    assign nz_count     = nz_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ap_bitserial_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_ap_bitserial_engine
// Description : Scoreboard bench for ap_bitserial_engine; directed vectors,
//               expected values queued by the driver, checked by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ap_bitserial_engine;

    localparam int W  = 8;
`ifdef AP_NZ_COUNT_EN
    localparam int CQ = 16;
    localparam int XL = CQ;
`else
    localparam int CQ = 512;
    localparam int XL = 0;
`endif
    localparam int AW = $clog2(CQ);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ap_mode = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    cmd = 3'd0;
    logic [AW-1:0] addr_in = '0;
    logic [1:0]    sel_col = 2'd0;
    logic [W-1:0]  data_in = '0;
    logic          write_en = 1'b0;
    logic          read_en = 1'b0;
    logic [W-1:0]  data_out;
    logic          busy;
    logic          irq;
`ifdef AP_NZ_COUNT_EN
    logic [$clog2(CQ+1)-1:0] nz_count;
`endif

    ap_bitserial_engine #(.WORD_SIZE(W), .CELL_QUANT(CQ)) dut (
        .CLK100MHZ    (clk),
        .rst          (rst),
        .ap_mode      (ap_mode),
        .start        (start),
        .cmd          (cmd),
        .addr_in      (addr_in),
        .sel_col      (sel_col),
        .data_in      (data_in),
        .write_en     (write_en),
        .read_en      (read_en),
        .data_out     (data_out),
        .busy         (busy),
`ifdef AP_NZ_COUNT_EN
        .nz_count     (nz_count),
`endif
        .ap_state_irq (irq)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int nz; } done_t;

    logic [W-1:0] rd_q [$];
    logic [9:0]   st_q [$];
    done_t        dn_q [$];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic rd_vld = 1'b0;
    logic stat_req = 1'b0;
    logic irq_prev = 1'b0;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rd_vld <= read_en;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic missing(input string nm);
        total++;
        bad++;
        $display("FAIL %s: DUT output with no queued expectation (cycle %0d)", nm, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT presents read data, status or done.
    always @(negedge clk) begin
        logic [W-1:0] er;
        logic [9:0]   es;
        done_t        ed;
        if (rd_vld) begin
            if (rd_q.size() == 0) missing("read");
            else begin er = rd_q.pop_front(); check("read_data", data_out, er); end
        end
        if (stat_req) begin
            if (st_q.size() == 0) missing("status");
            else begin es = st_q.pop_front(); check("status", {busy, irq, data_out}, es); end
        end
        if (irq && !irq_prev) begin
            if (dn_q.size() == 0) missing("done");
            else begin
                ed = dn_q.pop_front();
                check("done_cycle", cyc, ed.cyc);
`ifdef AP_NZ_COUNT_EN
                check("nz_count", nz_count, ed.nz);
`endif
            end
        end
        irq_prev = irq;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [1:0] s, input int a, input logic [W-1:0] d);
        sel_col = s; addr_in = AW'(a); data_in = d; write_en = 1'b1;
        step();
        write_en = 1'b0;
    endtask

    task automatic host_rd(input logic [1:0] s, input int a, input logic [W-1:0] e);
        rd_q.push_back(e);
        sel_col = s; addr_in = AW'(a); read_en = 1'b1;
        step();
        read_en = 1'b0;
    endtask

    task automatic stat(input logic [9:0] e);
        st_q.push_back(e);
        stat_req = 1'b1;
        step();
        stat_req = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] c, input int lat, input int nz, input bit pause);
        done_t d;
        bit    seen;
        ap_mode = 1'b1; start = 1'b1; cmd = c;
        step();
        start = 1'b0;
        d.cyc = cyc + lat;
        d.nz  = nz;
        dn_q.push_back(d);
        if (pause) begin
            repeat (30) step();
            ap_mode = 1'b0;
            host_wr(2'd0, 2, 8'h00);
            repeat (9) step();
            ap_mode = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < lat + 40 && !seen; i++) begin
            step();
            if (!busy && irq) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL op_timeout: busy=%0b irq=%0b expected done within %0d cycles", busy, irq, lat);
        end
        ap_mode = 1'b0;
        step();
    endtask

    task automatic read_c(input logic [W-1:0] c0, input logic [W-1:0] c1,
                          input logic [W-1:0] c2, input logic [W-1:0] c3);
        host_rd(2'd2, 0, c0);
        host_rd(2'd2, 1, c1);
        host_rd(2'd2, 2, c2);
        host_rd(2'd2, 3, c3);
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        stat(10'h000);

        for (int r = 0; r < CQ; r++) begin
            host_wr(2'd0, r, 8'h00);
            host_wr(2'd1, r, 8'h00);
        end

        // Host access, sel_col=3 read, same-cycle write/read returns old data
        host_wr(2'd0, 5, 8'hA5);
        host_rd(2'd0, 5, 8'hA5);
        host_rd(2'd3, 5, 8'h00);
        rd_q.push_back(8'hA5);
        sel_col = 2'd0; addr_in = AW'(5); data_in = 8'h3C; write_en = 1'b1; read_en = 1'b1;
        step();
        write_en = 1'b0; read_en = 1'b0;
        host_rd(2'd0, 5, 8'h3C);
        host_wr(2'd0, 5, 8'h00);

        host_wr(2'd0, 0, 8'h0F); host_wr(2'd1, 0, 8'hF0);
        host_wr(2'd0, 2, 8'hFF); host_wr(2'd1, 2, 8'h01);
        host_wr(2'd0, 3, 8'h37); host_wr(2'd1, 3, 8'h25);

        run_op(3'd0, 58 + XL, 3, 1'b0);
        read_c(8'hFF, 8'h00, 8'hFF, 8'h37);
        run_op(3'd3, 122 + XL, 2, 1'b0);
        read_c(8'hFF, 8'h00, 8'h00, 8'h5C);
        run_op(3'd2, 42 + XL, 3, 1'b0);
        read_c(8'hFF, 8'h00, 8'hFE, 8'h12);
        run_op(3'd1, 26 + XL, 2, 1'b0);
        read_c(8'h00, 8'h00, 8'h01, 8'h25);

        // ADD with a 10-cycle pause and an ignored host write
        run_op(3'd3, 132 + XL, 2, 1'b1);
        read_c(8'hFF, 8'h00, 8'h00, 8'h5C);
        host_rd(2'd0, 2, 8'hFF);

        // Abort OR at cycle 20
        ap_mode = 1'b1; start = 1'b1; cmd = 3'd0;
        step();
        start = 1'b0;
        repeat (19) step();
        rst = 1'b1;
        step();
        rst = 1'b0; ap_mode = 1'b0;
        stat(10'h000);
        run_op(3'd0, 58 + XL, 3, 1'b0);
        read_c(8'hFF, 8'h00, 8'hFF, 8'h37);

        // Illegal command: start ignored, done flag retained
        ap_mode = 1'b1; start = 1'b1; cmd = 3'd5;
        step();
        start = 1'b0;
        repeat (3) step();
        ap_mode = 1'b0;
        stat({2'b01, 8'h37});

        repeat (3) step();
        if (rd_q.size() != 0 || st_q.size() != 0 || dn_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: rd=%0d st=%0d done=%0d expected 0 pending", rd_q.size(), st_q.size(), dn_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
